cbi980_i2s_tx: RTL

- Serial back end of the CBI980 I2S controller, directly downstream of the controller core.
- Accepts 32-bit channel sample words over a valid/ready stream into a small FIFO.
- Generates BCLK and LRCLK from aclk and shifts samples out MSB-first on SDOUT.
- Reports FIFO level, a low-water interrupt request, and underrun events back to the core's status/IRQ logic.

---
 rtl/cbi980_i2s_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cbi980_i2s_tx.sv
// CBI980 I2S transmit back end: sample FIFO, BCLK/LRCLK divider and MSB-first serializer.
// Define CBI980_TX_LJ_EN to add the lj_mode input (left-justified slots).
module cbi980_i2s_tx #(
   parameter int CLK_DIV     = 4,
   parameter int SAMPLE_BITS = 24,
   parameter int FIFO_DEPTH  = 8,
   parameter int LOW_WATER   = 2
) (
   input  logic                        aclk,
   input  logic                        arstn,
   input  logic                        en,
   input  logic [31:0]                 s_data,
   input  logic                        s_valid,
`ifdef CBI980_TX_LJ_EN
   input  logic                        lj_mode,
`endif
   output logic                        s_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        irq_low,
   output logic                        underrun,
   output logic                        bclk,
   output logic                        lrclk,
   output logic                        sdout
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DM   = CLK_DIV - 1;
   localparam int SBM1I = SAMPLE_BITS - 1;
   localparam int DEPI = FIFO_DEPTH;
   localparam logic [DW-1:0] DIV_MAX = DM[DW-1:0];
   localparam logic [5:0]    SB6     = SAMPLE_BITS[5:0];
   localparam logic [4:0]    SBM1    = SBM1I[4:0];
   localparam logic [AW:0]   FULL    = DEPI[AW:0];

   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          wr, pop;

   logic [DW-1:0] div_cnt;
   logic [5:0]    bit_idx, bit_nxt;
   logic [31:0]   cur, word_nxt;
   logic          cur_lj, lj_nxt, lj_in;
   logic          start, slot, tick, fall, sd_nxt;
   logic [4:0]    p, ix;

`ifdef CBI980_TX_LJ_EN
   assign lj_in = lj_mode;
`else
   assign lj_in = 1'b0;
`endif

   assign s_ready    = (count != FULL);
   assign wr         = s_valid && s_ready;
   assign fifo_level = count;
   assign irq_low    = (state_q == RUN) && (int'(count) <= LOW_WATER);

   always_ff @(posedge aclk or negedge arstn)
      if (!arstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end

   always_ff @(posedge aclk)
      if (wr) mem[wptr] <= s_data;

   always_ff @(posedge aclk or negedge arstn)
      if (!arstn) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = IDLE;
      start   = 1'b0;
      slot    = 1'b0;
      tick    = (state_q == RUN) && (div_cnt == DIV_MAX);
      fall    = tick && bclk;
      if (en) begin
         state_d = RUN;
         start   = (state_q == IDLE);
         slot    = start || (fall && (bit_idx[4:0] == 5'd31));
      end
      bit_nxt  = start ? 6'd0 : bit_idx + {5'd0, fall};
      pop      = slot && (count != '0);
      word_nxt = slot ? (pop ? mem[rptr] : '0) : cur;
      lj_nxt   = slot ? lj_in : cur_lj;
      p        = bit_nxt[4:0];
      ix       = lj_nxt ? (SBM1 - p) : (SBM1 - p + 5'd1);
      sd_nxt   = 1'b0;
      // I2S p=0 still carries the outgoing slot's position 32 (its LSB only when 32-bit)
      if (lj_nxt) begin
         if ({1'b0, p} < SB6) sd_nxt = word_nxt[ix];
      end else if (p == 5'd0) begin
         sd_nxt = (SAMPLE_BITS == 32) && !cur_lj && cur[0];
      end else if ({1'b0, p} <= SB6) begin
         sd_nxt = word_nxt[ix];
      end
   end

   always_ff @(posedge aclk or negedge arstn)
      if (!arstn) begin
         div_cnt  <= '0;
         bclk     <= 1'b0;
         bit_idx  <= '0;
         lrclk    <= 1'b0;
         sdout    <= 1'b0;
         underrun <= 1'b0;
         cur      <= '0;
         cur_lj   <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         bclk     <= 1'b0;
         bit_idx  <= '0;
         lrclk    <= 1'b0;
         sdout    <= 1'b0;
         underrun <= 1'b0;
         cur      <= '0;
         cur_lj   <= 1'b0;
      end else begin
         div_cnt  <= (start || tick) ? '0 : div_cnt + 1'b1;
         if (tick) bclk <= ~bclk;
         bit_idx  <= bit_nxt;
         lrclk    <= bit_nxt[5];
         underrun <= slot && (count == '0);
         if (slot) begin
            cur    <= word_nxt;
            cur_lj <= lj_nxt;
         end
         if (start || fall) sdout <= sd_nxt;
      end
endmodule
